// File: rtl/tmds_pll_sequencer_pkg.sv
// tmds_pll_seq_pkg
// Shared definitions for the TMDS PLL bring-up sequencer: the FSM state
// enum (its encoding is visible on the debug state output), the default
// timing constants, and a helper that sizes counters from their limits.
// No ports.
package tmds_pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLL_RST   = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } seq_state_e;

    localparam int DEF_RST_CYCLES          = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int DEF_MAX_RETRIES         = 3;

    // A counter that must reach limit-1 needs $clog2(limit) bits; a limit
    // of 1 still needs one physical bit.
    function automatic int cnt_width(input int limit);
        return (limit <= 1) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/tmds_pll_sequencer_if.sv
// tmds_pll_seq_if
// Bundles the control and status signals of the TMDS PLL sequencer.
//   enable, pll_locked           : requests / PLL status into the sequencer
//   pll_rst, tx_rst              : resets driven by the sequencer
//   ready, fault                 : bring-up status
//   retry_count[3:0], state[2:0] : debug visibility
//   lol_count[7:0]               : loss-of-lock counter, only present when
//                                  TMDS_PLL_SEQ_LOL_CNT_EN is defined
// Modports: master = the sequencer, slave = the surrounding system.
interface tmds_pll_seq_if;

    logic       enable;
    logic       pll_locked;
    logic       pll_rst;
    logic       tx_rst;
    logic       ready;
    logic       fault;
    logic [3:0] retry_count;
    logic [2:0] state;
`ifdef TMDS_PLL_SEQ_LOL_CNT_EN
    logic [7:0] lol_count;

    modport master (
        input  enable, pll_locked,
        output pll_rst, tx_rst, ready, fault, retry_count, state, lol_count
    );
    modport slave (
        output enable, pll_locked,
        input  pll_rst, tx_rst, ready, fault, retry_count, state, lol_count
    );
`else
    modport master (
        input  enable, pll_locked,
        output pll_rst, tx_rst, ready, fault, retry_count, state
    );
    modport slave (
        output enable, pll_locked,
        input  pll_rst, tx_rst, ready, fault, retry_count, state
    );
`endif

endinterface

// File: rtl/tmds_pll_sequencer_sync_2ff.sv
// sync_2ff
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both flops
//   d   : asynchronous input
//   q   : synchronized output, two cycles of latency
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/tmds_pll_sequencer.sv
// tmds_pll_sequencer
// Sequences TMDS PLL bring-up: pulses the PLL reset, waits for lock with a
// timeout and bounded retries, requires a run of stable lock before
// releasing the serializer reset, and restarts the PLL on loss of lock.
//   refclk : reference clock, all logic runs on it
//   rst    : asynchronous active-high reset
//   bus    : tmds_pll_seq_if.master (enable/pll_locked in, resets/status out)
// Optional feature: define TMDS_PLL_SEQ_LOL_CNT_EN to add the saturating
// 8-bit loss-of-lock counter bus.lol_count.
module tmds_pll_sequencer
    import tmds_pll_seq_pkg::*;
#(
    parameter int RST_CYCLES          = DEF_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input logic           refclk,
    input logic           rst,
    tmds_pll_seq_if.master bus
);

    localparam int RST_W  = cnt_width(RST_CYCLES);
    localparam int STAB_W = cnt_width(LOCK_STABLE_CYCLES);
    localparam int TMO_W  = cnt_width(LOCK_TIMEOUT_CYCLES);

    localparam logic [RST_W-1:0]  RST_LAST    = RST_W'(RST_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_LAST   = STAB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]        RETRY_LIMIT = 4'(MAX_RETRIES);

    logic locked_s;

    seq_state_e  state_q, state_d;
    logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [3:0]  retry_q, retry_d;
    logic        pll_rst_q, pll_rst_d;
    logic        tx_rst_q, tx_rst_d;
    logic        ready_q, ready_d;
    logic        fault_q, fault_d;
`ifdef TMDS_PLL_SEQ_LOL_CNT_EN
    logic [7:0]  lol_q, lol_d;
`endif

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (bus.pll_locked),
        .q   (locked_s)
    );

    // Next-state logic. Each counter only advances while the FSM stays in
    // its own state, so every state entry starts it from zero and no
    // counter can run past its limit. Outputs are decoded from the next
    // state so that they are registered yet line up with the state flops.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;

        case (state_q)
            ST_IDLE:      state_d = ST_PLL_RST;
            ST_PLL_RST:   if (rst_cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = ST_STABLE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    retry_d = retry_q + 4'd1;
                    state_d = (retry_d == RETRY_LIMIT) ? ST_FAULT : ST_PLL_RST;
                end
            end
            ST_STABLE: begin
                if (!locked_s)                    state_d = ST_WAIT_LOCK;
                else if (stab_cnt_q == STAB_LAST) state_d = ST_RUN;
            end
            ST_RUN:       if (!locked_s) state_d = ST_PLL_RST;
            ST_FAULT:     state_d = ST_FAULT;
            default:      state_d = ST_IDLE;
        endcase

        // Dropping enable wins over everything, including FAULT.
        if (!bus.enable) state_d = ST_IDLE;
        if (state_d == ST_IDLE) retry_d = '0;

        rst_cnt_d  = (state_q == ST_PLL_RST   && state_d == ST_PLL_RST)   ? rst_cnt_q + RST_W'(1)   : '0;
        tmo_cnt_d  = (state_q == ST_WAIT_LOCK && state_d == ST_WAIT_LOCK) ? tmo_cnt_q + TMO_W'(1)   : '0;
        stab_cnt_d = (state_q == ST_STABLE    && state_d == ST_STABLE)    ? stab_cnt_q + STAB_W'(1) : '0;

        pll_rst_d = (state_d == ST_IDLE) || (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
        tx_rst_d  = (state_d != ST_RUN);
        ready_d   = (state_d == ST_RUN);
        fault_d   = (state_d == ST_FAULT);

`ifdef TMDS_PLL_SEQ_LOL_CNT_EN
        lol_d = lol_q;
        if (state_q == ST_RUN && state_d == ST_PLL_RST && lol_q != 8'hFF)
            lol_d = lol_q + 8'd1;
`endif
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rst_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            stab_cnt_q <= '0;
            retry_q    <= '0;
            pll_rst_q  <= 1'b1;
            tx_rst_q   <= 1'b1;
            ready_q    <= 1'b0;
            fault_q    <= 1'b0;
`ifdef TMDS_PLL_SEQ_LOL_CNT_EN
            lol_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            stab_cnt_q <= stab_cnt_d;
            retry_q    <= retry_d;
            pll_rst_q  <= pll_rst_d;
            tx_rst_q   <= tx_rst_d;
            ready_q    <= ready_d;
            fault_q    <= fault_d;
`ifdef TMDS_PLL_SEQ_LOL_CNT_EN
            lol_q      <= lol_d;
`endif
        end
    end

    assign bus.state       = state_q;
    assign bus.pll_rst     = pll_rst_q;
    assign bus.tx_rst      = tx_rst_q;
    assign bus.ready       = ready_q;
    assign bus.fault       = fault_q;
    assign bus.retry_count = retry_q;
`ifdef TMDS_PLL_SEQ_LOL_CNT_EN
    assign bus.lol_count   = lol_q;
`endif

endmodule
